neuron_event_scheduler: RTL and testbench

Sequencer that drives the control side of `neuron_core`. It accepts pre-synaptic spike events over a valid/ready handshake and sweeps every 4-neuron post group. Each group gets a read-then-write pass for the update, with synapse-array reads aligned to the post SRAM latency. It also runs whole-array time-step (`TSTEP`) and time-reference reset (`TREF`) sweeps. It sits between the input spike encoder/SPI domain and `neuron_core` plus the synapse SRAM.

---
 rtl/snn_ff_pkg.sv | 27 ++
 rtl/sweep_counter.sv | 22 ++
 rtl/neuron_event_scheduler.sv | 162 ++++++++++++++++
 tb/tb_neuron_event_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_ff_pkg.sv
// Shared types and helpers for the neuron_core control sequencer.
package snn_ff_pkg;

  typedef enum logic [3:0] {
    IDLE,
    EV_PRE,
    EV_RD,
    EV_WR,
    TS_RD,
    TS_WR,
    TR_RD,
    TR_WR,
    TR_PRE
  } sched_state_t;

  localparam int unsigned NEUR_PER_WORD = 4;

  function automatic int unsigned groups_of(input int unsigned n_post);
    return n_post / NEUR_PER_WORD;
  endfunction

  // Post SRAM word address: group index scaled by the 4 neurons per word.
  function automatic logic [9:0] post_addr(input logic [5:0] g);
    return {2'b00, g, 2'b00};
  endfunction

endpackage

// File: rtl/sweep_counter.sv
// Saturating up-counter stepping through 0..MAX-1 for one sweep.
module sweep_counter #(
  parameter int unsigned MAX = 64,
  parameter int unsigned W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  assign last = (cnt == W'(MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (en && !last) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/neuron_event_scheduler.sv
// Control sequencer for neuron_core: spike-event updates, time-step and
// time-reference sweeps over the post/pre neuron SRAMs and the synapse array.
module neuron_event_scheduler
  import snn_ff_pkg::*;
#(
  parameter int unsigned N_PRE  = 784,
  parameter int unsigned N_POST = 256,
  parameter int unsigned SYN_AW = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EVT_VALID,
  input  logic [9:0]        EVT_ADDR,
  output logic              EVT_READY,
  input  logic              TSTEP_REQ,
  input  logic              TREF_REQ,
  input  logic              SPI_GATE_ACTIVITY_sync,
  output logic [9:0]        CTRL_PRE_NEURON_ADDRESS,
  output logic [9:0]        CTRL_POST_NEURON_ADDRESS,
  output logic              CTRL_PRE_NEUR_CS,
  output logic              CTRL_PRE_NEUR_WE,
  output logic              CTRL_POST_NEUR_CS,
  output logic              CTRL_POST_NEUR_WE,
  output logic              CTRL_PRE_CNT_EN,
  output logic              CTRL_NEUR_EVENT,
  output logic              CTRL_TSTEP_EVENT,
  output logic              CTRL_TREF_EVENT,
  output logic              SYN_CS,
  output logic [SYN_AW-1:0] SYN_ADDR,
  output logic              BUSY,
  output logic              EVT_DONE,
  output logic              TSTEP_DONE,
  output logic              TREF_DONE
);

  localparam int unsigned GROUPS = groups_of(N_POST);
  localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned PW     = (N_PRE > 1) ? $clog2(N_PRE) : 1;

  sched_state_t      r_state, w_nxt;
  logic              r_idle, r_tref_pend, r_tstep_pend;
  logic [9:0]        r_evt_addr;
  logic [SYN_AW-1:0] r_syn_addr;
  logic              r_pre_cs, r_pre_we, r_cnt_en, r_post_cs, r_post_we, r_syn_cs;
  logic              r_neur_ev, r_tstep_ev, r_tref_ev, r_busy;
  logic              r_evt_done, r_tstep_done, r_tref_done;

  logic [GW-1:0] w_g;
  logic [PW-1:0] w_p;
  logic          w_g_last, w_p_last, w_g_clr, w_g_en, w_p_clr, w_p_en;
  logic          w_accept, w_tref_start, w_tstep_start;

  // Counters step on the same edge as the state change, so g/p are valid
  // in the cycle each RD/WR/PRE state is entered.
  assign w_g_clr = (r_state == IDLE);
  assign w_g_en  = (r_state == EV_WR) || (r_state == TS_WR) || (r_state == TR_WR);
  assign w_p_clr = (r_state != TR_PRE);
  assign w_p_en  = (r_state == TR_PRE);

  sweep_counter #(.MAX(GROUPS)) u_grp_cnt (
    .clk(CLK), .rst(RST), .clr(w_g_clr), .en(w_g_en), .cnt(w_g), .last(w_g_last)
  );

  sweep_counter #(.MAX(N_PRE)) u_pre_cnt (
    .clk(CLK), .rst(RST), .clr(w_p_clr), .en(w_p_en), .cnt(w_p), .last(w_p_last)
  );

  assign EVT_READY = r_idle & ~r_tref_pend & ~r_tstep_pend & ~SPI_GATE_ACTIVITY_sync;
  assign w_accept  = EVT_READY & EVT_VALID;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (!SPI_GATE_ACTIVITY_sync) begin
          if (r_tref_pend)       w_nxt = TR_RD;
          else if (r_tstep_pend) w_nxt = TS_RD;
          else if (w_accept)     w_nxt = EV_PRE;
        end
      end
      EV_PRE:  w_nxt = EV_RD;
      EV_RD:   w_nxt = EV_WR;
      EV_WR:   w_nxt = w_g_last ? IDLE : EV_RD;
      TS_RD:   w_nxt = TS_WR;
      TS_WR:   w_nxt = w_g_last ? IDLE : TS_RD;
      TR_RD:   w_nxt = TR_WR;
      TR_WR:   w_nxt = w_g_last ? TR_PRE : TR_RD;
      TR_PRE:  w_nxt = w_p_last ? IDLE : TR_PRE;
      default: w_nxt = IDLE;
    endcase
  end

  assign w_tref_start  = (r_state == IDLE) && (w_nxt == TR_RD);
  assign w_tstep_start = (r_state == IDLE) && (w_nxt == TS_RD);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_idle       <= 1'b0;
      r_tref_pend  <= 1'b0;
      r_tstep_pend <= 1'b0;
      r_evt_addr   <= '0;
      r_syn_addr   <= '0;
      r_pre_cs     <= 1'b0;
      r_pre_we     <= 1'b0;
      r_cnt_en     <= 1'b0;
      r_post_cs    <= 1'b0;
      r_post_we    <= 1'b0;
      r_syn_cs     <= 1'b0;
      r_neur_ev    <= 1'b0;
      r_tstep_ev   <= 1'b0;
      r_tref_ev    <= 1'b0;
      r_busy       <= 1'b0;
      r_evt_done   <= 1'b0;
      r_tstep_done <= 1'b0;
      r_tref_done  <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_idle       <= (w_nxt == IDLE);
      r_tref_pend  <= TREF_REQ  | (r_tref_pend  & ~w_tref_start);
      r_tstep_pend <= TSTEP_REQ | (r_tstep_pend & ~w_tstep_start);
      if (w_accept) begin
        r_evt_addr <= EVT_ADDR;
        r_syn_addr <= SYN_AW'(EVT_ADDR) * SYN_AW'(GROUPS);
      end else if (r_state == EV_WR && w_nxt == EV_RD) begin
        r_syn_addr <= r_syn_addr + SYN_AW'(1);
      end
      r_pre_cs     <= (w_nxt == EV_PRE) || (w_nxt == TR_PRE);
      r_pre_we     <= (w_nxt == EV_PRE) || (w_nxt == TR_PRE);
      r_cnt_en     <= (w_nxt == EV_PRE);
      r_post_cs    <= (w_nxt == EV_RD) || (w_nxt == EV_WR) || (w_nxt == TS_RD) ||
                      (w_nxt == TS_WR) || (w_nxt == TR_RD) || (w_nxt == TR_WR);
      r_post_we    <= (w_nxt == EV_WR) || (w_nxt == TS_WR) || (w_nxt == TR_WR);
      r_syn_cs     <= (w_nxt == EV_RD);
      r_neur_ev    <= (w_nxt == EV_PRE) || (w_nxt == EV_RD) || (w_nxt == EV_WR);
      r_tstep_ev   <= (w_nxt == TS_RD) || (w_nxt == TS_WR);
      r_tref_ev    <= (w_nxt == TR_RD) || (w_nxt == TR_WR) || (w_nxt == TR_PRE);
      r_busy       <= (w_nxt != IDLE);
      r_evt_done   <= (r_state == EV_WR)  && (w_nxt == IDLE);
      r_tstep_done <= (r_state == TS_WR)  && (w_nxt == IDLE);
      r_tref_done  <= (r_state == TR_PRE) && (w_nxt == IDLE);
    end
  end

  assign CTRL_PRE_NEURON_ADDRESS  = (r_state == TR_PRE) ? 10'(w_p) : r_evt_addr;
  assign CTRL_POST_NEURON_ADDRESS = post_addr(6'(w_g));
  assign CTRL_PRE_NEUR_CS         = r_pre_cs;
  assign CTRL_PRE_NEUR_WE         = r_pre_we;
  assign CTRL_POST_NEUR_CS        = r_post_cs;
  assign CTRL_POST_NEUR_WE        = r_post_we;
  assign CTRL_PRE_CNT_EN          = r_cnt_en;
  assign CTRL_NEUR_EVENT          = r_neur_ev;
  assign CTRL_TSTEP_EVENT         = r_tstep_ev;
  assign CTRL_TREF_EVENT          = r_tref_ev;
  assign SYN_CS                   = r_syn_cs;
  assign SYN_ADDR                 = r_syn_addr;
  assign BUSY                     = r_busy;
  assign EVT_DONE                 = r_evt_done;
  assign TSTEP_DONE               = r_tstep_done;
  assign TREF_DONE                = r_tref_done;

endmodule

// File: tb/tb_neuron_event_scheduler.sv
// Self-checking bench for neuron_event_scheduler: per-cycle expected operation
// lists are built from the sweep rules and compared against the DUT outputs.
module tb_neuron_event_scheduler;

  localparam int NP     = 784;
  localparam int NPOST  = 256;
  localparam int G      = NPOST / 4;
  localparam int EV_LEN = 2 + 2 * G;

  logic        clk = 1'b0;
  logic        RST, EVT_VALID, EVT_READY, TSTEP_REQ, TREF_REQ, GATE;
  logic [9:0]  EVT_ADDR, PRE_ADDR, POST_ADDR;
  logic        PRE_CS, PRE_WE, POST_CS, POST_WE, CNT_EN, NEV, TSEV, TREV;
  logic        SYN_CS, BUSY, EVT_DONE, TSTEP_DONE, TREF_DONE;
  logic [15:0] SYN_ADDR;

  always #5 clk = ~clk;

  neuron_event_scheduler #(.N_PRE(NP), .N_POST(NPOST), .SYN_AW(16)) dut (
    .CLK(clk), .RST(RST), .EVT_VALID(EVT_VALID), .EVT_ADDR(EVT_ADDR),
    .EVT_READY(EVT_READY), .TSTEP_REQ(TSTEP_REQ), .TREF_REQ(TREF_REQ),
    .SPI_GATE_ACTIVITY_sync(GATE),
    .CTRL_PRE_NEURON_ADDRESS(PRE_ADDR), .CTRL_POST_NEURON_ADDRESS(POST_ADDR),
    .CTRL_PRE_NEUR_CS(PRE_CS), .CTRL_PRE_NEUR_WE(PRE_WE),
    .CTRL_POST_NEUR_CS(POST_CS), .CTRL_POST_NEUR_WE(POST_WE),
    .CTRL_PRE_CNT_EN(CNT_EN), .CTRL_NEUR_EVENT(NEV),
    .CTRL_TSTEP_EVENT(TSEV), .CTRL_TREF_EVENT(TREV),
    .SYN_CS(SYN_CS), .SYN_ADDR(SYN_ADDR), .BUSY(BUSY),
    .EVT_DONE(EVT_DONE), .TSTEP_DONE(TSTEP_DONE), .TREF_DONE(TREF_DONE)
  );

  typedef struct packed {
    logic busy, rdy, edn, tsdn, trdn;
    logic pcs, pwe, cen, qcs, qwe, scs, nev, tsev, trev;
    logic [9:0]  pa;
    logic [9:0]  qa;
    logic [15:0] sa;
  } op_t;

  op_t         exp_q[$];
  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  localparam logic [49:0] RAW_RDY_ONLY = 50'd1 << 48;

  // Addresses only matter while their chip select is active.
  function automatic op_t observe();
    op_t o;
    o.busy = BUSY;    o.rdy = EVT_READY;
    o.edn  = EVT_DONE; o.tsdn = TSTEP_DONE; o.trdn = TREF_DONE;
    o.pcs  = PRE_CS;  o.pwe = PRE_WE; o.cen = CNT_EN;
    o.qcs  = POST_CS; o.qwe = POST_WE; o.scs = SYN_CS;
    o.nev  = NEV;     o.tsev = TSEV;   o.trev = TREV;
    o.pa   = PRE_CS  ? PRE_ADDR  : 10'd0;
    o.qa   = POST_CS ? POST_ADDR : 10'd0;
    o.sa   = SYN_CS  ? SYN_ADDR  : 16'd0;
    return o;
  endfunction

  function automatic logic [49:0] raw_outs();
    return {BUSY, EVT_READY, EVT_DONE, TSTEP_DONE, TREF_DONE, PRE_CS, PRE_WE,
            CNT_EN, POST_CS, POST_WE, SYN_CS, NEV, TSEV, TREV,
            PRE_ADDR, POST_ADDR, SYN_ADDR};
  endfunction

  function automatic op_t idle_op(logic rdy, logic ed, logic tsd, logic trd);
    op_t o = '0;
    o.rdy = rdy; o.edn = ed; o.tsdn = tsd; o.trdn = trd;
    return o;
  endfunction

  // One event: pre count bump, then read/write of every post group.
  function automatic void add_event(int a);
    op_t o;
    o = '0; o.busy = 1; o.pcs = 1; o.pwe = 1; o.cen = 1; o.nev = 1; o.pa = 10'(a);
    exp_q.push_back(o);
    for (int g = 0; g < G; g++) begin
      o = '0; o.busy = 1; o.nev = 1; o.qcs = 1; o.scs = 1;
      o.qa = 10'(4 * g); o.sa = 16'(a * G + g);
      exp_q.push_back(o);
      o = '0; o.busy = 1; o.nev = 1; o.qcs = 1; o.qwe = 1; o.qa = 10'(4 * g);
      exp_q.push_back(o);
    end
  endfunction

  function automatic void add_sweep(bit tref);
    op_t o;
    for (int g = 0; g < G; g++) begin
      o = '0; o.busy = 1; o.qcs = 1; o.tsev = !tref; o.trev = tref; o.qa = 10'(4 * g);
      exp_q.push_back(o);
      o.qwe = 1;
      exp_q.push_back(o);
    end
    if (tref) begin
      for (int p = 0; p < NP; p++) begin
        o = '0; o.busy = 1; o.pcs = 1; o.pwe = 1; o.trev = 1; o.pa = 10'(p);
        exp_q.push_back(o);
      end
    end
  endfunction

  task automatic test_reset();
    RST = 1'b1; EVT_VALID = 0; EVT_ADDR = '0; TSTEP_REQ = 0; TREF_REQ = 0; GATE = 0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (raw_outs() !== '0) begin
      err_cnt++; $display("FAIL reset_hold got %h exp %h", raw_outs(), 50'd0);
    end
    RST = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vec_cnt++;
    if (raw_outs() !== RAW_RDY_ONLY) begin
      err_cnt++; $display("FAIL reset_release got %h exp %h", raw_outs(), RAW_RDY_ONLY);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_event(input logic [9:0] a0, input int n);
    int  addrs[$];
    int  k;
    op_t got;
    addrs.push_back(int'(a0));
    for (int j = 1; j < n; j++) addrs.push_back(int'($urandom_range(NP - 1, 0)));
    exp_q.delete();
    exp_q.push_back(idle_op(1, 0, 0, 0));
    for (int j = 0; j < n; j++) begin
      add_event(addrs[j]);
      exp_q.push_back(idle_op(1, 1, 0, 0));
    end
    EVT_ADDR = a0; EVT_VALID = 1;
    for (int i = 0; i < int'(exp_q.size()); i++) begin
      @(negedge clk);
      got = observe();
      vec_cnt++;
      if (got !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL event a0=%0d n=%0d cyc %0d got %h exp %h", a0, n, i, got, exp_q[i]);
      end
      @(posedge clk); #1;
      if (i % EV_LEN == 0) begin
        k = i / EV_LEN;
        if (k + 1 < n) EVT_ADDR = 10'(addrs[k + 1]);
        else           EVT_VALID = 0;
      end
    end
  endtask

  task automatic test_back_to_back();
    test_event(10'($urandom_range(NP - 1, 0)), 3);
  endtask

  task automatic test_tref_tstep();
    op_t got;
    exp_q.delete();
    exp_q.push_back(idle_op(1, 0, 0, 0));
    exp_q.push_back(idle_op(0, 0, 0, 0));
    add_sweep(1);
    exp_q.push_back(idle_op(0, 0, 0, 1));
    add_sweep(0);
    exp_q.push_back(idle_op(1, 0, 1, 0));
    TREF_REQ = 1; TSTEP_REQ = 1;
    for (int i = 0; i < int'(exp_q.size()); i++) begin
      @(negedge clk);
      got = observe();
      vec_cnt++;
      if (got !== exp_q[i]) begin
        err_cnt++; $display("FAIL tref_tstep cyc %0d got %h exp %h", i, got, exp_q[i]);
      end
      @(posedge clk); #1;
      if (i == 0) begin TREF_REQ = 0; TSTEP_REQ = 0; end
    end
  endtask

  task automatic test_valid_during_tstep(input logic [9:0] b);
    op_t got;
    exp_q.delete();
    exp_q.push_back(idle_op(1, 0, 0, 0));
    exp_q.push_back(idle_op(0, 0, 0, 0));
    add_sweep(0);
    exp_q.push_back(idle_op(1, 0, 1, 0));
    add_event(int'(b));
    exp_q.push_back(idle_op(1, 1, 0, 0));
    repeat (4) exp_q.push_back(idle_op(1, 0, 0, 0));
    TSTEP_REQ = 1; EVT_VALID = 0;
    for (int i = 0; i < int'(exp_q.size()); i++) begin
      @(negedge clk);
      got = observe();
      vec_cnt++;
      if (got !== exp_q[i]) begin
        err_cnt++; $display("FAIL valid_in_tstep b=%0d cyc %0d got %h exp %h", b, i, got, exp_q[i]);
      end
      @(posedge clk); #1;
      if (i == 0) begin TSTEP_REQ = 0; EVT_VALID = 1; EVT_ADDR = b; end
      if (i == 2 + 2 * G) EVT_VALID = 0;
    end
  endtask

  task automatic test_gate(input logic [9:0] a, input logic [9:0] b);
    op_t got;
    exp_q.delete();
    exp_q.push_back(idle_op(1, 0, 0, 0));
    add_event(int'(a));
    exp_q.push_back(idle_op(0, 1, 0, 0));
    repeat (5) exp_q.push_back(idle_op(0, 0, 0, 0));
    exp_q.push_back(idle_op(1, 0, 0, 0));
    add_event(int'(b));
    exp_q.push_back(idle_op(1, 1, 0, 0));
    EVT_VALID = 1; EVT_ADDR = a;
    for (int i = 0; i < int'(exp_q.size()); i++) begin
      @(negedge clk);
      got = observe();
      vec_cnt++;
      if (got !== exp_q[i]) begin
        err_cnt++; $display("FAIL gate a=%0d b=%0d cyc %0d got %h exp %h", a, b, i, got, exp_q[i]);
      end
      @(posedge clk); #1;
      if (i == 0)   EVT_ADDR = b;
      if (i == 21)  GATE = 1;
      if (i == 135) GATE = 0;
      if (i == 136) EVT_VALID = 0;
    end
  endtask

  task automatic test_reset_mid();
    op_t got;
    int  bad;
    exp_q.delete();
    exp_q.push_back(idle_op(1, 0, 0, 0));
    exp_q.push_back(idle_op(0, 0, 0, 0));
    add_sweep(1);
    TREF_REQ = 1;
    for (int i = 0; i <= 2 + 2 * G + 300; i++) begin
      @(negedge clk);
      got = observe();
      vec_cnt++;
      if (got !== exp_q[i]) begin
        err_cnt++; $display("FAIL reset_mid_pre cyc %0d got %h exp %h", i, got, exp_q[i]);
      end
      if (i == 2 + 2 * G + 300) break;
      @(posedge clk); #1;
      if (i == 0) TREF_REQ = 0;
    end
    #1 RST = 1'b1;
    #1;
    vec_cnt++;
    if (raw_outs() !== '0) begin
      err_cnt++; $display("FAIL reset_mid_async got %h exp %h", raw_outs(), 50'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (BUSY || TREF_DONE || TREV) bad++;
    end
    vec_cnt++;
    if (bad !== 0) begin
      err_cnt++; $display("FAIL reset_mid_no_resume got %0d active cycles exp 0", bad);
    end
    got = observe();
    vec_cnt++;
    if (got !== idle_op(1, 0, 0, 0)) begin
      err_cnt++; $display("FAIL reset_mid_idle got %h exp %h", got, idle_op(1, 0, 0, 0));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_event(10'd5, 1);
    test_event(10'd0, 1);
    test_event(10'(NP - 1), 1);
    test_back_to_back();
    test_tref_tstep();
    test_valid_during_tstep(10'($urandom_range(NP - 1, 0)));
    test_gate(10'($urandom_range(NP - 1, 0)), 10'($urandom_range(NP - 1, 0)));
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
